// File: rtl/seg_scan_driver.sv
//----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a DIGITS-wide common-anode seven-segment
// display. Keeps a shadow copy of the hex word, the per-digit decimal points
// and the per-digit blank flags. Lights one digit at a time for CLK_DIV
// cycles. Between digits it inserts a single all-dark guard cycle so that a
// segment pattern never ghosts onto its neighbour.
//
// Parameters:
//   DIGITS   number of digits scanned (1..8)
//   CLK_DIV  cycles each digit stays lit (>= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       shadow capture strobe
//   data_in    hex nibbles, nibble i at [4i+3:4i], digit 0 least significant
//   dp_in      decimal point request per digit, active-high
//   blank_in   force digit dark, active-high
//   seg_out    segments g..a, active-low, registered
//   dp_out     decimal point, active-low, registered
//   dig_sel    one-cold digit enable, active-low, registered
//   scan_done  one-cycle pulse when the scan wraps back to digit 0
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a digit whose nibble is zero and whose more significant
//   nibbles are all zero is shown dark (digit 0 excepted). Its decimal point
//   still follows dp_in. When undefined, leading zeros are displayed.
//----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int DIGITS  = 4,
   parameter int CLK_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  scan_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [6:0]    DARK      = 7'h7F;

   typedef enum logic {
      GUARD,
      SCAN
   } state_t;

   state_t                stateQ;
   logic [IW-1:0]         idxQ;
   logic [IW-1:0]         idxD;
   logic [PW-1:0]         prescQ;

   logic [4*DIGITS-1:0]   shadowDataQ;
   logic [DIGITS-1:0]     shadowDpQ;
   logic [DIGITS-1:0]     shadowBlankQ;

   logic [6:0]            segQ;
   logic [6:0]            segD;
   logic                  dpOutQ;
   logic                  dpOutD;
   logic [DIGITS-1:0]     selQ;
   logic [DIGITS-1:0]     selD;
   logic                  doneQ;
   logic [DIGITS-1:0]     lzDark;
   logic [3:0]            nibD;

   // Hex nibble to active-low segment pattern, bit 6 = g down to bit 0 = a.
   function automatic logic [6:0] glyphOf(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Shadow copy of the display contents. Captured on any edge with load
   // high, so the scan always works from a stable snapshot even when the
   // register logic upstream is changing data_in every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadowDataQ  <= '0;
         shadowDpQ    <= '0;
         shadowBlankQ <= '0;
      end else if (load) begin
         shadowDataQ  <= data_in;
         shadowDpQ    <= dp_in;
         shadowBlankQ <= blank_in;
      end
   end

   // Leading-zero suppression mask. Walk down from the most significant
   // digit and keep marking digits dark while every nibble seen so far is
   // zero. Digit 0 is never included so a value of zero still shows "0".
   always_comb begin
      lzDark = '0;
`ifdef LEADING_ZERO_BLANK_EN
      begin
         logic upperZero;
         upperZero = 1'b1;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            upperZero = upperZero & (shadowDataQ[4*i +: 4] == 4'h0);
            lzDark[i] = upperZero;
         end
      end
`endif
   end

   // Everything the next lit digit will show, computed from the shadow as
   // it stands before the entry edge. A load coinciding with that edge is
   // therefore only seen from the following digit onwards.
   always_comb begin
      idxD   = (idxQ == LAST_IDX) ? '0 : idxQ + 1'b1;
      nibD   = shadowDataQ[4*idxD +: 4];
      segD   = glyphOf(nibD);
      dpOutD = ~shadowDpQ[idxD];
      if (lzDark[idxD]) begin
         segD = DARK;
      end
      if (shadowBlankQ[idxD]) begin
         segD   = DARK;
         dpOutD = 1'b1;
      end
      selD = ~(DIGITS'(1) << idxD);
   end

   // Scan FSM. GUARD is a single dark cycle; on leaving it the next digit
   // is latched into the output registers and stays frozen for the whole
   // SCAN interval. The prescaler runs only while a digit is lit, so a digit
   // occupies CLK_DIV cycles and a frame DIGITS*(CLK_DIV+1) cycles.
   // Reset parks the index on the last digit so the first entry is digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= GUARD;
         idxQ   <= LAST_IDX;
         prescQ <= '0;
         segQ   <= DARK;
         dpOutQ <= 1'b1;
         selQ   <= '1;
         doneQ  <= 1'b0;
      end else begin
         case (stateQ)
            GUARD: begin
               stateQ <= SCAN;
               idxQ   <= idxD;
               prescQ <= '0;
               segQ   <= segD;
               dpOutQ <= dpOutD;
               selQ   <= selD;
               doneQ  <= (idxD == '0);
            end
            SCAN: begin
               doneQ <= 1'b0;
               if (prescQ == PRESC_MAX) begin
                  stateQ <= GUARD;
                  prescQ <= '0;
                  segQ   <= DARK;
                  dpOutQ <= 1'b1;
                  selQ   <= '1;
               end else begin
                  prescQ <= prescQ + 1'b1;
               end
            end
         endcase
      end
   end

   assign seg_out   = segQ;
   assign dp_out    = dpOutQ;
   assign dig_sel   = selQ;
   assign scan_done = doneQ;

endmodule

// File: tb/tb_seg_scan_driver.sv
//----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Drives seg_scan_driver (DIGITS=4, CLK_DIV=4) with directed and randomized
// loads and compares every output on every cycle against a frame-arithmetic
// model: the digit and slot shown at any cycle follow directly from the
// number of edges since reset release. Literal expectations taken from the
// display's documented examples pin the model.
//----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 4;
   localparam int PERIOD  = CLK_DIV + 1;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                load = 1'b0;
   logic [4*DIGITS-1:0] data_in = '0;
   logic [DIGITS-1:0]   dp_in = '0;
   logic [DIGITS-1:0]   blank_in = '0;
   logic [6:0]          seg_out;
   logic                dp_out;
   logic [DIGITS-1:0]   dig_sel;
   logic                scan_done;

   int totalChecks = 0;
   int badChecks   = 0;
   int cyc         = 0;

   int                  edgeCount = 0;
   logic [4*DIGITS-1:0] mData  = '0;
   logic [DIGITS-1:0]   mDp    = '0;
   logic [DIGITS-1:0]   mBlank = '0;
   logic [6:0]          entrySeg = 7'h7F;
   logic                entryDp  = 1'b1;

   seg_scan_driver #(
      .DIGITS  (DIGITS),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .data_in   (data_in),
      .dp_in     (dp_in),
      .blank_in  (blank_in),
      .seg_out   (seg_out),
      .dp_out    (dp_out),
      .dig_sel   (dig_sel),
      .scan_done (scan_done)
   );

   always #5 clk = ~clk;

   // Frame position of the cycle following edge number c (c >= 1).
   function automatic int slotOf(input int c);
      return (c - 1) % PERIOD;
   endfunction

   function automatic int digitOf(input int c);
      return ((c - 1) / PERIOD) % DIGITS;
   endfunction

   // What digit d shows given the model shadow: {dp_out, seg_out}.
   function automatic logic [7:0] glyphFor(input int d);
      logic [4*DIGITS-1:0] sh;
      logic [6:0]          s;
      logic                p;
      sh = mData >> (4 * d);
      s  = GLYPH[sh[3:0]];
      p  = ~mDp[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && sh == '0) s = 7'h7F;
`endif
      if (mBlank[d]) begin
         s = 7'h7F;
         p = 1'b1;
      end
      return {p, s};
   endfunction

   function automatic logic isLit();
      return (edgeCount > 0) && (slotOf(edgeCount) != CLK_DIV);
   endfunction

   function automatic logic [DIGITS-1:0] expSel();
      logic [DIGITS-1:0] one;
      one = DIGITS'(1);
      if (!isLit()) return '1;
      return ~(one << digitOf(edgeCount));
   endfunction

   function automatic logic [6:0] expSeg();
      return isLit() ? entrySeg : 7'h7F;
   endfunction

   function automatic logic expDp();
      return isLit() ? entryDp : 1'b1;
   endfunction

   function automatic logic expDone();
      return (edgeCount > 0) && (slotOf(edgeCount) == 0) && (digitOf(edgeCount) == 0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [4*DIGITS-1:0] d,
                                input logic [DIGITS-1:0] p, input logic [DIGITS-1:0] b);
      load     = ld;
      data_in  = d;
      dp_in    = p;
      blank_in = b;
   endtask

   task automatic stepTo(input int target);
      while (cyc < target) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic checkLit(input string name, input logic [DIGITS-1:0] sel,
                           input logic [6:0] seg, input logic dp);
      checkOutput({name, " sel"}, 32'(dig_sel), 32'(sel));
      checkOutput({name, " seg"}, 32'(seg_out), 32'(seg));
      checkOutput({name, " dp"},  32'(dp_out),  32'(dp));
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, " sel"},  32'(dig_sel),   32'(4'hF));
      checkOutput({name, " seg"},  32'(seg_out),   32'(7'h7F));
      checkOutput({name, " dp"},   32'(dp_out),    32'(1'b1));
      checkOutput({name, " done"}, 32'(scan_done), 32'(1'b0));
   endtask

   // Reference model: counts edges since reset release and snapshots the
   // glyph of each digit at its entry edge from the shadow before capture.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            edgeCount = 0;
            mData     = '0;
            mDp       = '0;
            mBlank    = '0;
         end else begin
            edgeCount++;
            if (slotOf(edgeCount) == 0) begin
               {entryDp, entrySeg} = glyphFor(digitOf(edgeCount));
            end
            if (load) begin
               mData  = data_in;
               mDp    = dp_in;
               mBlank = blank_in;
            end
         end
      end
   end

   // Every-cycle comparison against the model, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("model sel",  32'(dig_sel),   32'(expSel()));
         checkOutput("model seg",  32'(seg_out),   32'(expSeg()));
         checkOutput("model dp",   32'(dp_out),    32'(expDp()));
         checkOutput("model done", 32'(scan_done), 32'(expDone()));
      end
   end

   initial begin
      applyStimulus(1'b0, '0, '0, '0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      cyc   = 0;

      stepTo(1);
      checkLit("first entry", 4'b1110, 7'h40, 1'b1);
      checkOutput("first done", 32'(scan_done), 32'd1);
      stepTo(5);
      checkLit("guard", 4'b1111, 7'h7F, 1'b1);
      stepTo(6);
      checkOutput("digit1 sel", 32'(dig_sel), 32'(4'b1101));
      stepTo(20);
      checkOutput("no done 20", 32'(scan_done), 32'd0);
      stepTo(21);
      checkOutput("second done", 32'(scan_done), 32'd1);

      applyStimulus(1'b1, 16'hA5F3, 4'b0100, 4'b0000);
      stepTo(22);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);
      stepTo(41);
      checkLit("A5F3 d0", 4'b1110, 7'h30, 1'b1);
      stepTo(46);
      checkLit("A5F3 d1", 4'b1101, 7'h0E, 1'b1);
      stepTo(51);
      checkLit("A5F3 d2", 4'b1011, 7'h12, 1'b0);
      stepTo(56);
      checkLit("A5F3 d3", 4'b0111, 7'h08, 1'b1);

      applyStimulus(1'b1, 16'h8888, 4'b1010, 4'b1010);
      stepTo(57);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);
      stepTo(61);
      checkLit("blank d0", 4'b1110, 7'h00, 1'b1);
      stepTo(66);
      checkLit("blank d1", 4'b1101, 7'h7F, 1'b1);
      stepTo(71);
      checkLit("blank d2", 4'b1011, 7'h00, 1'b1);
      stepTo(76);
      checkLit("blank d3", 4'b0111, 7'h7F, 1'b1);

      stepTo(86);
      checkLit("pre midload d1", 4'b1101, 7'h7F, 1'b1);
      stepTo(87);
      applyStimulus(1'b1, 16'h8878, 4'b0000, 4'b0000);
      stepTo(88);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);
      stepTo(89);
      checkLit("midload frozen d1", 4'b1101, 7'h7F, 1'b1);
      stepTo(101);
      checkLit("midload d0", 4'b1110, 7'h00, 1'b1);
      stepTo(106);
      checkLit("midload new d1", 4'b1101, 7'h78, 1'b1);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
         stepTo(cyc + 1);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);

      for (int i = 0; i < 2 * DIGITS * PERIOD; i++) begin
         if (digitOf(cyc) == 2 && slotOf(cyc) == 1) break;
         stepTo(cyc + 1);
      end
      checkOutput("pre reset on d2", 32'(dig_sel), 32'(4'b1011));
      #2 rst_n = 1'b0;
      #1 checkResetValues("async reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      stepTo(1);
      checkLit("restart d0", 4'b1110, 7'h40, 1'b1);
      checkOutput("restart done", 32'(scan_done), 32'd1);

      applyStimulus(1'b1, 16'h0040, 4'b1000, 4'b0000);
      stepTo(2);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);
`ifdef LEADING_ZERO_BLANK_EN
      stepTo(21);
      checkLit("lzb d0", 4'b1110, 7'h40, 1'b1);
      stepTo(26);
      checkLit("lzb d1", 4'b1101, 7'h19, 1'b1);
      stepTo(31);
      checkLit("lzb d2", 4'b1011, 7'h7F, 1'b1);
      stepTo(36);
      checkLit("lzb d3", 4'b0111, 7'h7F, 1'b0);
`else
      stepTo(21);
      checkLit("zeros d0", 4'b1110, 7'h40, 1'b1);
      stepTo(26);
      checkLit("zeros d1", 4'b1101, 7'h19, 1'b1);
      stepTo(31);
      checkLit("zeros d2", 4'b1011, 7'h40, 1'b1);
      stepTo(36);
      checkLit("zeros d3", 4'b0111, 7'h40, 1'b0);
`endif
      applyStimulus(1'b1, 16'h0000, 4'b0000, 4'b0000);
      stepTo(37);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);
      stepTo(41);
      checkLit("all zero d0", 4'b1110, 7'h40, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
      stepTo(46);
      checkLit("all zero d1", 4'b1101, 7'h7F, 1'b1);
      stepTo(56);
      checkLit("all zero d3", 4'b0111, 7'h7F, 1'b1);
`else
      stepTo(46);
      checkLit("all zero d1", 4'b1101, 7'h40, 1'b1);
      stepTo(56);
      checkLit("all zero d3", 4'b0111, 7'h40, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It is the parametrised successor of the team's single-digit hex-to-segment decoder. The block holds a shadow copy of the hex word, per-digit decimal points and blank flags. It scans one digit at a time at a programmable rate, with a one-cycle ghosting guard between digits. It sits between the register/status logic and the board's segment and digit-enable pins.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8
- CLK_DIV, 50000, clock cycles each digit stays lit; must be >= 2
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  shadow capture strobe
- data_in  input  4*DIGITS  hex nibbles; nibble i at [4i+3:4i], digit 0 is least significant
- dp_in  input  DIGITS  decimal point request per digit, active-high
- blank_in  input  DIGITS  force digit i dark, active-high
- seg_out  output  7  segments g..a on [6:0], active-low, registered
- dp_out  output  1  decimal point, active-low, registered
- dig_sel  output  DIGITS  one-cold digit enable, active-low, registered
- scan_done  output  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Shadow registers: data_in, dp_in and blank_in are captured on any edge with load=1. The shadow holds otherwise. It resets to all zeros.
- Glyph table for seg_out, nibble 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Dark glyph is 7F.
- FSM states:
  - GUARD: dig_sel all ones, seg_out=7F, dp_out=1. Lasts exactly one cycle.
  - SCAN: one digit lit.
- GUARD -> SCAN on the next edge, unconditionally. At that edge:
  - index advances; it wraps from DIGITS-1 to 0.
  - dig_sel[index]=0.
  - seg_out and dp_out are loaded from shadow nibble/dp[index].
  - If shadow blank[index]=1, seg_out=7F and dp_out=1.
- SCAN -> GUARD when prescaler == CLK_DIV-1. The prescaler counts only in SCAN and clears on leaving SCAN.
- seg_out, dp_out and dig_sel are frozen for the whole SCAN interval. A load during SCAN takes effect at the next digit entry, never mid-digit.
- scan_done is 1 for exactly the cycle after the edge where index wraps to 0. With DIGITS=1 it pulses on every entry.
- index width is clog2(DIGITS), minimum 1 bit.

## Timing
- Reset values:
  - seg_out=7F, dp_out=1, dig_sel all ones, scan_done=0.
  - state=GUARD, index=DIGITS-1, prescaler=0, shadow=0.
- First edge after rst_n deasserts enters digit 0: dig_sel[0]=0, seg_out=40, scan_done=1.
- Each digit is lit for exactly CLK_DIV cycles. Frame period is DIGITS*(CLK_DIV+1) cycles.
- load-to-display latency: from 1 cycle (load on the edge just before the GUARD->SCAN edge) to CLK_DIV+1 cycles.
- load on the GUARD->SCAN edge itself: the entering digit uses the old shadow; the new value appears from the next digit.
- Reset asserted mid-scan forces the reset values immediately (asynchronous). No partial digit survives.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: a digit is dark when its shadow nibble is 0 and every more significant nibble is also 0.
  - Digit 0 is never blanked by this rule.
  - dp_in still lights dp_out on a digit blanked by this rule. blank_in still overrides everything.
  - Not defined: every non-blanked digit shows its glyph, including leading zeros.

## Test plan
- Reset release, DIGITS=4, CLK_DIV=4, shadow 0 -> cycle 1:
  - dig_sel=1110, seg_out=40, scan_done=1.
  - Cycle 5 is a guard cycle: dig_sel=1111, seg_out=7F.
  - Cycle 6: dig_sel=1101.
  - Next scan_done pulse at cycle 21.
- load with data_in=16'hA5F3, dp_in=4'b0100 -> across digits 0..3:
  - seg_out is 30, 0E, 12, 08 in that order.
  - dp_out=0 only on digit 2.
- blank_in=4'b1010 with data 16'h8888 -> digits 1 and 3 show 7F with dp_out=1; digits 0 and 2 show 00.
- load pulsed mid-SCAN of digit 1 with a new nibble -> digit 1 output is unchanged until its next entry one frame later.
- rst_n pulsed low during digit 2 -> outputs go to reset values with no clock edge. The scan restarts at digit 0 after release.
- LEADING_ZERO_BLANK_EN defined, data_in=16'h0040, dp_in=4'b1000:
  - digit 3 shows seg_out=7F with dp_out=0.
  - digit 2 shows 7F.
  - digit 1 shows 19.
  - digit 0 shows 40.
  - With data_in=16'h0000, only digit 0 shows 40.
